// File: rtl/muldiv_exec_pkg.sv
// muldiv_exec_pkg: op/state encodings and register-bank constants shared with the bank
package muldiv_exec_pkg;
  localparam int ADDR_W = 5;
  localparam int NREGS = 18;
  localparam logic [63:0] DIV0_Q = '1;
  typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_DIV, OP_REM} op_t;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_CALC, S_WRITE} state_t;
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: operand/accumulator registers, shift-add multiply and restoring divide step
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  muldiv_exec_pkg::op_t          op,
  input  logic                          load,
  input  logic                          step,
  input  logic [WIDTH-1:0]              a_in,
  input  logic [WIDTH-1:0]              b_in,
  output logic                          div0,
  output logic [WIDTH-1:0]              result
);
  import muldiv_exec_pkg::*;
  logic [WIDTH-1:0] a, b, r, q;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH:0] sum, rs, t;
  // one multiply or divide iteration plus the divide-by-zero check on the incoming divisor
  always_comb begin
    div0 = op[1] & ~|b_in;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, b[0] ? a : '0};
    rs = {r, q[WIDTH-1]};
    t = rs - {1'b0, b};
    result = op == OP_MUL ? p[WIDTH-1:0] : op == OP_MULH ? p[2*WIDTH-1:WIDTH] : op == OP_DIV ? q : r;
  end
  // load operands in READ (div-by-zero results preset here), then iterate in CALC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a <= '0;
      b <= '0;
      p <= '0;
      r <= '0;
      q <= '0;
    end else if (load) begin
      a <= a_in;
      b <= b_in;
      p <= '0;
      q <= div0 ? DIV0_Q[WIDTH-1:0] : a_in;
      r <= div0 ? a_in : '0;
    end else if (step) begin
      if (op[1]) begin
        r <= t[WIDTH] ? rs[WIDTH-1:0] : t[WIDTH-1:0];
        q <= {q[WIDTH-2:0], ~t[WIDTH]};
      end else begin
        p <= {sum, p[WIDTH-1:1]};
        b <= b >> 1;
      end
    end
  end
endmodule

// File: rtl/muldiv_exec.sv
// muldiv_exec: iterative unsigned MUL/MULH/DIV/REM unit driving the register bank ports
module muldiv_exec #(
  parameter int WIDTH = 32,
  parameter int ADDR_W = muldiv_exec_pkg::ADDR_W,
  parameter int NREGS = muldiv_exec_pkg::NREGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic [ADDR_W-1:0] dst,
  output logic [ADDR_W-1:0] sr1,
  output logic [ADDR_W-1:0] sr2,
  input  logic [WIDTH-1:0]  rData1,
  input  logic [WIDTH-1:0]  rData2,
  output logic [ADDR_W-1:0] dr,
  output logic [WIDTH-1:0]  wrData,
  output logic              write,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import muldiv_exec_pkg::*;
  localparam int CW = $clog2(WIDTH);
  state_t state, nxt;
  op_t op_q;
  logic [CW-1:0] cnt;
  logic div0, bad_dst, err_q;
  muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk(clk), .reset(reset), .op(op_q), .load(state == S_READ), .step(state == S_CALC),
    .a_in(rData1), .b_in(rData2), .div0(div0), .result(wrData)
  );
  // state, issue latches, iteration counter and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      op_q <= OP_MUL;
      sr1 <= '0;
      sr2 <= '0;
      dr <= '0;
      cnt <= '0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= state == S_CALC ? cnt + 1'b1 : '0;
      if (state == S_IDLE && start) begin
        op_q <= op_t'(op);
        sr1 <= src1;
        sr2 <= src2;
        dr <= dst;
        err_q <= 1'b0;
      end
      if ((state == S_READ && div0) || (state == S_WRITE && bad_dst)) err_q <= 1'b1;
    end
  end
  // next state and handshake/bank-write outputs
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  nxt = start ? S_READ : S_IDLE;
      S_READ:  nxt = div0 ? S_WRITE : S_CALC;
      S_CALC:  nxt = cnt == CW'(WIDTH - 1) ? S_WRITE : S_CALC;
      default: nxt = S_IDLE;
    endcase
    busy = state != S_IDLE;
    done = state == S_WRITE;
    bad_dst = dr >= ADDR_W'(NREGS);
    write = done & ~bad_dst;
    err = err_q | (done & bad_dst);
  end
endmodule

// File: tb/tb_muldiv_exec.sv
// tb_muldiv_exec: directed MUL/MULH/DIV/REM vectors against a small register-bank model
module tb_muldiv_exec;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [1:0] op = 2'd0;
  logic [4:0] src1 = '0, src2 = '0, dst = '0;
  logic [4:0] sr1, sr2, dr;
  logic [31:0] rData1, rData2, wrData;
  logic write, busy, done, err;
  logic [31:0] bank [18];
  logic ld = 1'b0;
  logic [4:0] ld_a = '0;
  logic [31:0] ld_v = '0;
  int total = 0, bad = 0, wr_cnt = 0;

  muldiv_exec dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src1(src1), .src2(src2), .dst(dst),
    .sr1(sr1), .sr2(sr2), .rData1(rData1), .rData2(rData2), .dr(dr), .wrData(wrData),
    .write(write), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign rData1 = sr1 < 5'd18 ? bank[sr1] : 32'd0;
  assign rData2 = sr2 < 5'd18 ? bank[sr2] : 32'd0;

  always @(posedge clk) begin
    if (ld) bank[ld_a] <= ld_v;
    else if (write) begin
      if (dr < 5'd18) bank[dr] <= wrData;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] v);
    ld = 1'b1;
    ld_a = a;
    ld_v = v;
    @(posedge clk);
    #1 ld = 1'b0;
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [4:0] a, input logic [4:0] b,
                     input logic [4:0] d, input logic [31:0] exp_d, input logic exp_w, input logic exp_e,
                     input int exp_lat, input bit poke);
    int cyc;
    op = o;
    src1 = a;
    src2 = b;
    dst = d;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_sr1"}, sr1, a);
    while (!done && cyc < 100) begin
      if (poke && cyc == 10) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc++;
      if (poke && cyc == 11) chk({tag, "_poke_busy"}, busy, 1);
    end
    chk({tag, "_lat"}, cyc, exp_lat);
    chk({tag, "_dr"}, dr, d);
    chk({tag, "_data"}, wrData, exp_d);
    chk({tag, "_write"}, write, exp_w);
    chk({tag, "_err"}, err, exp_e);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({tag, "_idle"}, {busy, write, done}, 3'b000);
    chk({tag, "_hold"}, wrData, exp_d);
  endtask

  initial begin
    int w0;
    #2;
    chk("rst_out", {sr1, sr2, dr, write, busy, done, err}, '0);
    chk("rst_data", wrData, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 18; i++) preload(5'(i), 32'd0);
    preload(5'd1, 32'd50000);
    preload(5'd2, 32'd100000);
    preload(5'd5, 32'd250000);
    preload(5'd6, 32'd7);
    preload(5'd8, 32'd123);
    preload(5'd10, 32'hFFFF_FFFF);
    run("mul", 2'd0, 5'd1, 5'd2, 5'd3, 32'h2A05_F200, 1, 0, 34, 0);
    run("mulh", 2'd1, 5'd1, 5'd2, 5'd4, 32'h0000_0001, 1, 0, 34, 0);
    run("mulh_max", 2'd1, 5'd10, 5'd10, 5'd11, 32'hFFFF_FFFE, 1, 0, 34, 0);
    run("mul_max", 2'd0, 5'd10, 5'd10, 5'd12, 32'h0000_0001, 1, 0, 34, 0);
    run("div", 2'd2, 5'd5, 5'd6, 5'd7, 32'd35714, 1, 0, 34, 0);
    run("rem", 2'd3, 5'd5, 5'd6, 5'd13, 32'd2, 1, 0, 34, 0);
    run("div0", 2'd2, 5'd8, 5'd9, 5'd14, 32'hFFFF_FFFF, 1, 1, 2, 0);
    run("rem0", 2'd3, 5'd8, 5'd9, 5'd15, 32'd123, 1, 1, 2, 0);
    run("bad_dst", 2'd0, 5'd6, 5'd6, 5'd20, 32'd49, 0, 1, 34, 1);
    run("r0", 2'd0, 5'd6, 5'd6, 5'd0, 32'd49, 1, 0, 34, 0);
    chk("bank_r0", bank[0], 49);
    chk("bank_r3", bank[3], 32'h2A05_F200);
    chk("bank_r7", bank[7], 35714);
    chk("bank_r14", bank[14], 32'hFFFF_FFFF);
    w0 = wr_cnt;
    op = 2'd0;
    src1 = 5'd1;
    src2 = 5'd2;
    dst = 5'd16;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("abort_out", {sr1, sr2, dr, write, busy, done, err}, '0);
    chk("abort_data", wrData, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_nowrite", wr_cnt, w0);
    chk("abort_bank", bank[16], 0);
    run("mul_after", 2'd0, 5'd1, 5'd2, 5'd17, 32'h2A05_F200, 1, 0, 34, 0);
    chk("bank_r17", bank[17], 32'h2A05_F200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_exec.md
Name: muldiv_exec

Overview:
- Iterative unsigned multiply/divide execute unit sitting beside the 18-entry register bank (R0-R15, SP, PC).
- Drives the bank's read addresses, captures both operands, and computes over 32 cycles.
- Writes the result back through the bank's write port (dr/wrData/write).
- Frees the single-cycle ALU path from MUL/DIV instructions; the controller issues one op with a start pulse and waits for done.

Parameters:
- WIDTH, 32, data width of operands and result.
- ADDR_W, 5, register address width.
- NREGS, 18, number of valid register indices (0..NREGS-1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle issue strobe; sampled only in IDLE.
- op  in  2  00 MUL (low word), 01 MULH (high word), 10 DIV (quotient), 11 REM (remainder); all unsigned.
- src1  in  ADDR_W  first operand register (multiplicand/dividend).
- src2  in  ADDR_W  second operand register (multiplier/divisor).
- dst  in  ADDR_W  destination register.
- sr1  out  ADDR_W  to bank read port 1.
- sr2  out  ADDR_W  to bank read port 2.
- rData1  in  WIDTH  from bank, combinational read of sr1.
- rData2  in  WIDTH  from bank, combinational read of sr2.
- dr  out  ADDR_W  to bank write address.
- wrData  out  WIDTH  to bank write data.
- write  out  1  to bank write enable, one-cycle pulse.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky-until-next-start flag: dst out of range or divide by zero.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; sr1, sr2, dr = 0; wrData = 0; write, busy, done, err = 0; the iteration counter and accumulators clear.
- Reset mid-operation aborts the op with no bank write.
- States: IDLE, READ, CALC, WRITE.
- IDLE:
  - On start=1, latch op, src1->sr1, src2->sr2, dst->dr, clear err, and go to READ.
  - start is ignored in every other state.
- READ (1 cycle):
  - Capture rData1 and rData2 into operand registers A and B.
  - Counter=0. The bank read is combinational, so the operands are valid this cycle.
  - MUL/MULH: 2*WIDTH accumulator P = 0; go to CALC.
  - DIV/REM with B=0: set err; quotient result = all ones, remainder result = A; go straight to WRITE.
  - DIV/REM otherwise: remainder R = 0, quotient Q = A; go to CALC.
- CALC (exactly WIDTH cycles, counter 0..WIDTH-1, then WRITE):
  - MUL: if B[0], add A into the upper half of P with carry out; shift {carry, P} right by 1; shift B right by 1.
  - DIV (restoring): shift {R, Q} left by 1; trial T = R - B at WIDTH+1 bits; if T is non-negative, R = T and Q[0] = 1.
- WRITE (1 cycle):
  - wrData = selected result: P[WIDTH-1:0], P[2*WIDTH-1:WIDTH], Q, or R.
  - write=1 only if dr < NREGS; otherwise write=0 and err=1.
  - done=1. Return to IDLE.
  - wrData and dr hold their values until the next accepted start.
- busy: 1 in READ, CALC and WRITE; 0 in IDLE.
- Latency: start accepted at cycle 0; write/done at cycle WIDTH+2 (34 for the default). Divide-by-zero completes at cycle 2.
- Back-to-back: a start in the cycle done is high is ignored. The earliest accepted start is the cycle after done.
- R0 is an ordinary register: dst=0 is written.

Decomposition:
- Shared package:
  - op encodings (OP_MUL, OP_MULH, OP_DIV, OP_REM);
  - state encodings;
  - NREGS and ADDR_W constants, shared with the register bank;
  - the divide-by-zero quotient constant.
- One natural sub-module, muldiv_datapath: holds the accumulators, the shift/add/subtract step, and result select. muldiv_exec keeps the FSM, counter, handshake and bank interface.

Test Plan:
- Preload bank r1=50000, r2=100000; start MUL src1=1 src2=2 dst=3 -> at cycle 34 write=1, dr=3, wrData=0x2A05F200 (5e9 mod 2^32), done=1, err=0.
- Same operands with MULH, dst=4 -> wrData=0x00000001; with r1=r2=0xFFFFFFFF, MULH -> 0xFFFFFFFE and MUL -> 0x00000001.
- r5=250000, r6=7; DIV src1=5 src2=6 dst=7 -> wrData=35714; REM -> wrData=2; both done at cycle 34.
- Divisor register=0, dividend=123: DIV -> wrData=0xFFFFFFFF and REM -> wrData=123; err=1 and done at cycle 2.
- dst=20: write stays 0, err=1, done=1. A start pulsed at cycle 10 mid-op is ignored and busy stays 1.
- Assert reset=0 at cycle 15 of a MUL -> outputs zero immediately, no write pulse ever; after release, a new MUL completes normally.
